spm_bank_array: RTL
===================

Name: spm_bank_array

Overview:
- Parametrised successor to the fixed 4-bank-group scratchpad.
- Provides NUM_BANKS independent banks, each run-time configurable as addressed RAM or FIFO.
- Each bank's write source is selectable between the external bus and the switch network.
- Adds full/empty/occupancy status, sticky overflow/underflow flags, per-bank flush and an IDLE/LOADED/RUN control FSM.
- Sits between the external load/store bus and the PE-array switch ports.

Parameters:
- NUM_BANKS, 4, number of independent banks.
- DATA_W, 32, word width.
- ADDR_W, 8, address width; depth per bank is 2**ADDR_W.
- CFG_W, 4, config bits per bank: {flush, en, sel, mode}.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- inst  in  NUM_BANKS*CFG_W  packed config; bank b occupies [b*CFG_W +: CFG_W].
- init  in  1  latch inst and apply flushes.
- run  in  1  start accepting accesses.
- ex_wen  in  NUM_BANKS  external write enable per bank.
- ex_ren  in  NUM_BANKS  external read enable per bank.
- ex_addr  in  NUM_BANKS*ADDR_W  external address.
- ex_wdata  in  NUM_BANKS*DATA_W  external write data.
- sw_wen  in  NUM_BANKS  switch write enable.
- sw_ren  in  NUM_BANKS  switch read enable.
- sw_addr  in  NUM_BANKS*ADDR_W  switch address.
- sw_wdata  in  NUM_BANKS*DATA_W  switch write data.
- rd_data  out  NUM_BANKS*DATA_W  read data.
- rd_valid  out  NUM_BANKS  rd_data valid, one-cycle pulse.
- full  out  NUM_BANKS  FIFO full.
- empty  out  NUM_BANKS  FIFO empty.
- count  out  NUM_BANKS*(ADDR_W+1)  FIFO occupancy.
- ovf  out  NUM_BANKS  sticky overflow.
- unf  out  NUM_BANKS  sticky underflow.
- active  out  1  FSM in RUN.

Behaviour:
- Reset values:
  - FSM IDLE; latched config 0.
  - Pointers 0, count 0, empty=1, full=0.
  - rd_data 0, rd_valid 0, ovf/unf 0, active 0.
  - Memory contents are not reset.
- FSM:
  - IDLE --init--> LOADED.
  - LOADED --run--> RUN.
  - RUN --init--> LOADED.
  - init has priority over run in the same cycle.
  - Accesses are ignored outside RUN.
- Config latch: on an init cycle inst is registered. Banks with flush=1 clear wr/rd pointers, count, ovf and unf in that same edge. The flush bit is not retained.
- Source select: sel=0 uses the ex_* signals, sel=1 uses the sw_* signals. The unselected source is ignored entirely.
- Disabled bank (en=0): all accesses are ignored, contents and pointers are held, rd_valid stays 0.
- RAM mode (mode=0):
  - Write mem[addr] at the edge.
  - Read: rd_data=mem[addr] one cycle after ren, with rd_valid pulsed.
  - Read and write to the same address in the same cycle returns the OLD data.
  - count/full/empty are frozen in RAM mode.
- FIFO mode (mode=1):
  - addr is ignored.
  - Pointers wrap modulo 2**ADDR_W.
  - full = (count == 2**ADDR_W); empty = (count == 0).
  - Write when full: dropped, ovf set.
  - Read when empty: no rd_valid, unf set.
  - Simultaneous read+write, neither full nor empty: both occur, count unchanged.
  - Simultaneous read+write when full: both occur.
  - Simultaneous read+write when empty: write accepted, read rejected (unf set, no bypass).
  - Read latency is 1 cycle.
- Mode change via init without flush: pointers are kept; the user is responsible for them.
- Reset mid-RUN: everything returns to reset values the next edge, and the in-flight read's rd_valid is suppressed.
- All banks are fully independent; bank b never affects bank c.

Decomposition:
- Header spm_bank_defines.v holds:
  - CFG field offsets: MODE=0, SEL=1, EN=2, FLUSH=3.
  - FSM state encodings: IDLE=0, LOADED=1, RUN=2.
  - Default parameter values.
- Sub-module spm_bank:
  - Contains one bank's memory, pointers, counters, flags and source mux.
  - The top instantiates it NUM_BANKS times via generate.
  - The top itself holds only the FSM, config register and bus slicing.

Test Plan:
- Reset, then init with all banks {en=1,mode=1,sel=0}, then run, then write 1,11,111,1111 to banks 3..0 for 3 cycles (values incrementing), then read 3 cycles -> banks return 1,2,3 / 11,12,13 / 111,112,113 / 1111,1112,1113 in order with rd_valid, count 3→0, empty=1.
- FIFO fill with ADDR_W=2: 4 writes then a 5th -> full=1 after the 4th; 5th dropped; ovf=1; reading 4 returns the first 4 values only.
- Simultaneous read+write when empty then when full -> empty case: count becomes 1, unf=1. Full case: count stays 4, rd_data = oldest word.
- RAM mode bank 0, sel=1: sw write 0xA5 to addr 7, then in one cycle read addr 7 and write 0x5A to addr 7 -> rd_data=0xA5; next read returns 0x5A; ex_* traffic to bank 0 is ignored.
- Accesses in LOADED state, en=0, and re-init with flush=1 on bank 2 only -> no writes land before run; disabled bank holds data; bank 2 count=0, ovf/unf cleared; other banks unchanged.
- Reset asserted mid-stream with reads pending -> next cycle rd_valid=0, count=0, empty=1, active=0.

Source files
------------

// File: rtl/spm_bank_array_pkg.sv
// Shared definitions for the scratchpad bank array: config field offsets,
// control FSM state encodings and default parameter values.
package spm_bank_array_pkg;

  // Per-bank config word layout: {flush, en, sel, mode}.
  localparam int unsigned CfgMode  = 0;
  localparam int unsigned CfgSel   = 1;
  localparam int unsigned CfgEn    = 2;
  localparam int unsigned CfgFlush = 3;

  localparam int unsigned DefNumBanks = 4;
  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefAddrW    = 8;
  localparam int unsigned DefCfgW     = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoaded = 2'd1,
    StRun    = 2'd2
  } state_e;

endpackage

// File: rtl/spm_bank_array_bank.sv
// One scratchpad bank: memory, FIFO pointers, occupancy, sticky flags and the
// source mux.
// Ports: clk/rst; flush clears pointers/count/flags; acc_en gates all
// accesses; mode/sel/en are the latched config bits; ex_* and sw_* are the two
// access sources; rd_data/rd_valid is the registered read result;
// full/empty/count/ovf/unf are the FIFO status outputs.
module spm_bank_array_bank
  import spm_bank_array_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              acc_en,
  input  logic              mode,
  input  logic              sel,
  input  logic              en,
  input  logic              ex_wen,
  input  logic              ex_ren,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              sw_wen,
  input  logic              sw_ren,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              unf
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(Depth);

  logic [DATA_W-1:0] mem [Depth];

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, unf_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic              wen, ren;
  logic [ADDR_W-1:0] addr, waddr, raddr;
  logic [DATA_W-1:0] wdata;
  logic              is_full, is_empty, do_wr, do_rd;

  always_comb begin
    wen   = acc_en & en & ~rst & (sel ? sw_wen : ex_wen);
    ren   = acc_en & en & ~rst & (sel ? sw_ren : ex_ren);
    addr  = sel ? sw_addr : ex_addr;
    wdata = sel ? sw_wdata : ex_wdata;

    is_full  = (count_q == DepthCnt);
    is_empty = (count_q == '0);

    // A full FIFO still accepts a write when a read frees the slot in the same
    // cycle; an empty FIFO never bypasses write data to the read side.
    do_rd = ren & (~mode | ~is_empty);
    do_wr = wen & (~mode | ~is_full | do_rd);

    waddr = mode ? wr_ptr_q : addr;
    raddr = mode ? rd_ptr_q : addr;

    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_d = count_q - 1'b1;
    end
  end

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_rd;
      if (do_rd) begin
        rd_data_q <= mem[raddr];
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
        unf_q    <= 1'b0;
      end else if (mode) begin
        if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
        if (wen && !do_wr) ovf_q <= 1'b1;
        if (ren && !do_rd) unf_q <= 1'b1;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign full     = is_full;
  assign empty    = is_empty;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: rtl/spm_bank_array.sv
// Scratchpad bank array between the external load/store bus and the PE-array
// switch ports. Holds the IDLE/LOADED/RUN control FSM, the config register and
// the per-bank bus slicing; each bank is an spm_bank_array_bank instance.
// Ports: clk/rst; inst packed per-bank config {flush,en,sel,mode}; init latches
// inst and applies flushes; run starts accesses; ex_*/sw_* per-bank access
// buses; rd_data/rd_valid read results; full/empty/count/ovf/unf status;
// active is high in RUN.
module spm_bank_array
  import spm_bank_array_pkg::*;
#(
  parameter int unsigned NUM_BANKS = DefNumBanks,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned CFG_W     = DefCfgW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BANKS*CFG_W-1:0]    inst,
  input  logic                          init,
  input  logic                          run,
  input  logic [NUM_BANKS-1:0]          ex_wen,
  input  logic [NUM_BANKS-1:0]          ex_ren,
  input  logic [NUM_BANKS*ADDR_W-1:0]   ex_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]   ex_wdata,
  input  logic [NUM_BANKS-1:0]          sw_wen,
  input  logic [NUM_BANKS-1:0]          sw_ren,
  input  logic [NUM_BANKS*ADDR_W-1:0]   sw_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]   sw_wdata,
  output logic [NUM_BANKS*DATA_W-1:0]   rd_data,
  output logic [NUM_BANKS-1:0]          rd_valid,
  output logic [NUM_BANKS-1:0]          full,
  output logic [NUM_BANKS-1:0]          empty,
  output logic [NUM_BANKS*(ADDR_W+1)-1:0] count,
  output logic [NUM_BANKS-1:0]          ovf,
  output logic [NUM_BANKS-1:0]          unf,
  output logic                          active
);

  state_e state_q, state_d;
  logic [NUM_BANKS*CFG_W-1:0] cfg_q;
  logic [NUM_BANKS*CFG_W-1:0] flush_mask;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (init) state_d = StLoaded;
      StLoaded: if (!init && run) state_d = StRun;
      StRun:    if (init) state_d = StLoaded;
      default:  state_d = StIdle;
    endcase
  end

  // The flush bit acts only on the init edge and is never stored.
  always_comb begin
    flush_mask = '1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      flush_mask[b*CFG_W+CfgFlush] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (init) cfg_q <= inst & flush_mask;
    end
  end

  assign active = (state_q == StRun);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    spm_bank_array_bank #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .flush    (init & inst[b*CFG_W+CfgFlush]),
      .acc_en   (active),
      .mode     (cfg_q[b*CFG_W+CfgMode]),
      .sel      (cfg_q[b*CFG_W+CfgSel]),
      .en       (cfg_q[b*CFG_W+CfgEn]),
      .ex_wen   (ex_wen[b]),
      .ex_ren   (ex_ren[b]),
      .ex_addr  (ex_addr[b*ADDR_W +: ADDR_W]),
      .ex_wdata (ex_wdata[b*DATA_W +: DATA_W]),
      .sw_wen   (sw_wen[b]),
      .sw_ren   (sw_ren[b]),
      .sw_addr  (sw_addr[b*ADDR_W +: ADDR_W]),
      .sw_wdata (sw_wdata[b*DATA_W +: DATA_W]),
      .rd_data  (rd_data[b*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[b]),
      .full     (full[b]),
      .empty    (empty[b]),
      .count    (count[b*(ADDR_W+1) +: ADDR_W+1]),
      .ovf      (ovf[b]),
      .unf      (unf[b])
    );
  end

endmodule
